// File: rtl/encode_opnd_bytes_if.sv
// rtl/encode_opnd_bytes_if.sv - instruction-field and byte-stream bundle for encode_opnd_bytes
//
// Purpose: carries one x86 instruction's fields into the encoder and the
// serialized little-endian byte stream out of it.
// Ports (signals):
//   in_valid/in_ready        instruction handshake (in_ready from encoder)
//   prefix_operand_16bit     0x66 prefix, selects imm16 unless imm_1byte
//   prefix_address_16bit     0x67 prefix, suppresses SIB
//   escape                   0x0F escape before the opcode
//   opcode, modrm, sib       raw bytes; has_modrm qualifies modrm
//   disp_only8/disp_only32   displacement-only forms when has_modrm=0
//   disp, imm                32-bit values, emitted low byte first
//   has_imm, imm_1byte       immediate presence and 1-byte form
//   out_valid/out_ready      byte handshake (out_ready from consumer)
//   out_byte, out_last       current byte and end-of-instruction marker
//   instr_len                byte count of the instruction being emitted
// Modports: master drives the fields and out_ready; slave is the encoder.

interface encode_opnd_bytes_if;
    logic        in_valid;
    logic        in_ready;
    logic        prefix_operand_16bit;
    logic        prefix_address_16bit;
    logic        escape;
    logic [7:0]  opcode;
    logic        has_modrm;
    logic [7:0]  modrm;
    logic [7:0]  sib;
    logic        disp_only8;
    logic        disp_only32;
    logic [31:0] disp;
    logic        has_imm;
    logic        imm_1byte;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;
    logic [3:0]  instr_len;

    modport master (
        output in_valid, prefix_operand_16bit, prefix_address_16bit, escape,
               opcode, has_modrm, modrm, sib, disp_only8, disp_only32, disp,
               has_imm, imm_1byte, imm, out_ready,
        input  in_ready, out_valid, out_byte, out_last, instr_len
    );

    modport slave (
        input  in_valid, prefix_operand_16bit, prefix_address_16bit, escape,
               opcode, has_modrm, modrm, sib, disp_only8, disp_only32, disp,
               has_imm, imm_1byte, imm, out_ready,
        output in_ready, out_valid, out_byte, out_last, instr_len
    );
endinterface

// File: rtl/encode_opnd_bytes.sv
// rtl/encode_opnd_bytes.sv - serializing x86 instruction encoder, one byte per cycle
//
// Purpose: latches one instruction's fields on accept and emits
// [66][67][0F] opcode [ModR/M][SIB][disp][imm] little-endian, one byte per
// out_valid/out_ready transfer. SIB/disp/imm presence mirrors the decoder.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset; aborts any instruction in flight
//   bus    encode_opnd_bytes_if.slave (instruction fields in, byte stream out)

module encode_opnd_bytes (
    input  logic               clk,
    input  logic               rst_n,
    encode_opnd_bytes_if.slave bus
);
    // Declaration order matters: next-field selection compares state ordinals.
    typedef enum logic [3:0] {
        IDLE, P66, P67, ESC, OPC, MODRM, SIB, DISP, IMM
    } state_e;

    state_e      state_q;
    logic        p66_q, p67_q, esc_q, has_modrm_q, has_sib_q;
    logic [7:0]  opcode_q, modrm_q, sib_q;
    logic [31:0] disp_q, imm_q;
    logic [2:0]  disp_len_q, imm_len_q;
    logic [1:0]  cnt_q;
    logic [3:0]  pos_q;
    logic [3:0]  instr_len_q;
    logic [7:0]  out_byte_q;
    logic        out_last_q, out_valid_q, in_ready_q;

    // Field decode on the live inputs, used only at the accept edge.
    logic [1:0]  acc_mod;
    logic [2:0]  acc_rm;
    logic        acc_reg_direct, acc_has_sib;
    logic [2:0]  acc_disp_len, acc_imm_len;
    logic [3:0]  acc_len;
    state_e      acc_first;
    logic [7:0]  acc_first_byte;

    always_comb begin
        acc_mod        = bus.modrm[7:6];
        acc_rm         = bus.modrm[2:0];
        acc_reg_direct = bus.has_modrm && (acc_mod == 2'b11);
        acc_has_sib    = bus.has_modrm && !bus.prefix_address_16bit &&
                         !acc_reg_direct && (acc_rm == 3'b100);

        acc_disp_len = 3'd0;
        if (bus.has_modrm) begin
            if (!acc_reg_direct) begin
                if (acc_mod == 2'b10 || (acc_mod == 2'b00 && acc_rm == 3'b101))
                    acc_disp_len = 3'd4;
                else if (acc_mod == 2'b01)
                    acc_disp_len = 3'd1;
            end
        end else if (bus.disp_only32) begin
            acc_disp_len = 3'd4;
        end else if (bus.disp_only8) begin
            acc_disp_len = 3'd1;
        end

        if (!bus.has_imm)                  acc_imm_len = 3'd0;
        else if (bus.imm_1byte)            acc_imm_len = 3'd1;
        else if (bus.prefix_operand_16bit) acc_imm_len = 3'd2;
        else                               acc_imm_len = 3'd4;

        acc_len = {3'd0, bus.prefix_operand_16bit} + {3'd0, bus.prefix_address_16bit} +
                  {3'd0, bus.escape} + 4'd1 + {3'd0, bus.has_modrm} +
                  {3'd0, acc_has_sib} + {1'b0, acc_disp_len} + {1'b0, acc_imm_len};

        if (bus.prefix_operand_16bit) begin
            acc_first      = P66;
            acc_first_byte = 8'h66;
        end else if (bus.prefix_address_16bit) begin
            acc_first      = P67;
            acc_first_byte = 8'h67;
        end else if (bus.escape) begin
            acc_first      = ESC;
            acc_first_byte = 8'h0F;
        end else begin
            acc_first      = OPC;
            acc_first_byte = bus.opcode;
        end
    end

    // Where the FSM goes after the current byte transfers, and that byte's value.
    state_e     state_d;
    logic [1:0] cnt_d;
    logic [7:0] byte_d;

    always_comb begin
        state_d = IMM;
        cnt_d   = 2'd0;
        if (state_q == DISP && ({1'b0, cnt_q} + 3'd1) < disp_len_q) begin
            state_d = DISP;
            cnt_d   = cnt_q + 2'd1;
        end else if (state_q == IMM && ({1'b0, cnt_q} + 3'd1) < imm_len_q) begin
            state_d = IMM;
            cnt_d   = cnt_q + 2'd1;
        end else if (state_q < P67 && p67_q) begin
            state_d = P67;
        end else if (state_q < ESC && esc_q) begin
            state_d = ESC;
        end else if (state_q < OPC) begin
            state_d = OPC;
        end else if (state_q < MODRM && has_modrm_q) begin
            state_d = MODRM;
        end else if (state_q < SIB && has_sib_q) begin
            state_d = SIB;
        end else if (state_q < DISP && disp_len_q != 3'd0) begin
            state_d = DISP;
        end

        case (state_d)
            P66:     byte_d = 8'h66;
            P67:     byte_d = 8'h67;
            ESC:     byte_d = 8'h0F;
            OPC:     byte_d = opcode_q;
            MODRM:   byte_d = modrm_q;
            SIB:     byte_d = sib_q;
            DISP:    byte_d = disp_q[{cnt_d, 3'b000} +: 8];
            IMM:     byte_d = imm_q[{cnt_d, 3'b000} +: 8];
            default: byte_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            p66_q       <= 1'b0;
            p67_q       <= 1'b0;
            esc_q       <= 1'b0;
            has_modrm_q <= 1'b0;
            has_sib_q   <= 1'b0;
            opcode_q    <= 8'h00;
            modrm_q     <= 8'h00;
            sib_q       <= 8'h00;
            disp_q      <= 32'h0;
            imm_q       <= 32'h0;
            disp_len_q  <= 3'd0;
            imm_len_q   <= 3'd0;
            cnt_q       <= 2'd0;
            pos_q       <= 4'd0;
            instr_len_q <= 4'd0;
            out_byte_q  <= 8'h00;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        p66_q       <= bus.prefix_operand_16bit;
                        p67_q       <= bus.prefix_address_16bit;
                        esc_q       <= bus.escape;
                        has_modrm_q <= bus.has_modrm;
                        has_sib_q   <= acc_has_sib;
                        opcode_q    <= bus.opcode;
                        modrm_q     <= bus.modrm;
                        sib_q       <= bus.sib;
                        disp_q      <= bus.disp;
                        imm_q       <= bus.imm;
                        disp_len_q  <= acc_disp_len;
                        imm_len_q   <= acc_imm_len;
                        cnt_q       <= 2'd0;
                        pos_q       <= 4'd0;
                        instr_len_q <= acc_len;
                        state_q     <= acc_first;
                        out_byte_q  <= acc_first_byte;
                        out_last_q  <= (acc_len == 4'd1);
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b0;
                    end
                end
                default: begin
                    if (bus.out_ready) begin
                        if (out_last_q) begin
                            // Always one IDLE cycle before the next accept.
                            state_q     <= IDLE;
                            out_last_q  <= 1'b0;
                            out_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                        end else begin
                            state_q    <= state_d;
                            cnt_q      <= cnt_d;
                            out_byte_q <= byte_d;
                            pos_q      <= pos_q + 4'd1;
                            // Next byte index is pos_q+1; it is last when it equals len-1.
                            out_last_q <= ((pos_q + 4'd2) == instr_len_q);
                        end
                    end
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_byte  = out_byte_q;
    assign bus.out_last  = out_last_q;
    assign bus.instr_len = instr_len_q;

endmodule

// File: tb/tb_encode_opnd_bytes.sv
// tb/tb_encode_opnd_bytes.sv - directed self-checking bench for encode_opnd_bytes

module tb_encode_opnd_bytes;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    encode_opnd_bytes_if bus ();

    encode_opnd_bytes dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic clear_fields();
        bus.in_valid             = 1'b0;
        bus.prefix_operand_16bit = 1'b0;
        bus.prefix_address_16bit = 1'b0;
        bus.escape               = 1'b0;
        bus.opcode               = 8'h00;
        bus.has_modrm            = 1'b0;
        bus.modrm                = 8'h00;
        bus.sib                  = 8'h00;
        bus.disp_only8           = 1'b0;
        bus.disp_only32          = 1'b0;
        bus.disp                 = 32'h0;
        bus.has_imm              = 1'b0;
        bus.imm_1byte            = 1'b0;
        bus.imm                  = 32'h0;
    endtask

    // Garbage on the fields after accept; the encoder must use its latched copy.
    task automatic scramble_fields();
        bus.prefix_operand_16bit = 1'($urandom);
        bus.prefix_address_16bit = 1'($urandom);
        bus.escape               = 1'($urandom);
        bus.opcode               = 8'($urandom);
        bus.has_modrm            = 1'($urandom);
        bus.modrm                = 8'($urandom);
        bus.sib                  = 8'($urandom);
        bus.disp                 = $urandom;
        bus.has_imm              = 1'($urandom);
        bus.imm                  = $urandom;
    endtask

    task automatic set_case1();
        clear_fields();
        bus.opcode    = 8'h81;
        bus.has_modrm = 1'b1;
        bus.modrm     = 8'h44;
        bus.sib       = 8'h88;
        bus.disp      = 32'h10;
        bus.has_imm   = 1'b1;
        bus.imm       = 32'h12345678;
    endtask

    // mode 0: ready high; 1: ready toggles; 2: toggles plus a 5-cycle stall on byte 3.
    // Called at a negedge with the DUT idle and the fields already set.
    task automatic run_instr(input string name, input logic [7:0] exp[$], input int mode);
        int   idx = 0;
        int   cyc = 0;
        int   stall = 0;
        logic rdy;
        check({name, "/idle_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        scramble_fields();
        while (idx < exp.size() && cyc < 200) begin
            check({name, "/valid"}, 32'(bus.out_valid), 32'd1);
            check({name, "/in_ready"}, 32'(bus.in_ready), 32'd0);
            check({name, "/len"}, 32'(bus.instr_len), 32'(exp.size()));
            check($sformatf("%s/byte%0d", name, idx), 32'(bus.out_byte), 32'(exp[idx]));
            check($sformatf("%s/last%0d", name, idx), 32'(bus.out_last),
                  32'(idx == exp.size() - 1));
            if (mode == 0) rdy = 1'b1;
            else if (mode == 2 && idx == 3 && stall < 5) begin
                rdy = 1'b0;
                stall++;
            end else rdy = cyc[0];
            bus.out_ready = rdy;
            if (rdy) idx++;
            cyc++;
            @(posedge clk);
            @(negedge clk);
        end
        check({name, "/completed"}, 32'(idx), 32'(exp.size()));
        check({name, "/done_valid"}, 32'(bus.out_valid), 32'd0);
        check({name, "/done_ready"}, 32'(bus.in_ready), 32'd1);
        if (mode == 0) check({name, "/cycles"}, 32'(cyc), 32'(exp.size()));
        bus.out_ready = 1'b1;
        clear_fields();
    endtask

    initial begin
        logic [7:0] exp[$];
        clear_fields();
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("rst/in_ready", 32'(bus.in_ready), 32'd1);
        check("rst/out_valid", 32'(bus.out_valid), 32'd0);
        check("rst/out_byte", 32'(bus.out_byte), 32'd0);
        check("rst/out_last", 32'(bus.out_last), 32'd0);
        check("rst/instr_len", 32'(bus.instr_len), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // SIB + disp8 + imm32
        set_case1();
        exp = '{8'h81, 8'h44, 8'h88, 8'h10, 8'h78, 8'h56, 8'h34, 8'h12};
        run_instr("sib_imm", exp, 0);

        // disp32 via mod=00 rm=101
        bus.opcode = 8'h8B; bus.has_modrm = 1'b1; bus.modrm = 8'h05;
        bus.disp = 32'hDEADBEEF;
        exp = '{8'h8B, 8'h05, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_instr("disp32", exp, 0);

        // Both prefixes, escape, register-direct rm=100 (no SIB), imm16
        bus.prefix_operand_16bit = 1'b1; bus.prefix_address_16bit = 1'b1;
        bus.escape = 1'b1; bus.opcode = 8'hAF; bus.has_modrm = 1'b1;
        bus.modrm = 8'hC4; bus.sib = 8'h99; bus.has_imm = 1'b1; bus.imm = 32'h0000ABCD;
        exp = '{8'h66, 8'h67, 8'h0F, 8'hAF, 8'hC4, 8'hCD, 8'hAB};
        run_instr("pfx_imm16", exp, 0);

        // 16-bit addressing suppresses SIB even with rm=100 mod=00
        bus.prefix_address_16bit = 1'b1; bus.opcode = 8'h8B;
        bus.has_modrm = 1'b1; bus.modrm = 8'h04; bus.sib = 8'h24;
        exp = '{8'h67, 8'h8B, 8'h04};
        run_instr("a16_nosib", exp, 0);

        // disp_only8 and disp_only32 together: disp32 wins
        bus.opcode = 8'hA1; bus.disp_only8 = 1'b1; bus.disp_only32 = 1'b1;
        bus.disp = 32'h11223344;
        exp = '{8'hA1, 8'h44, 8'h33, 8'h22, 8'h11};
        run_instr("disp_both", exp, 0);

        // Opcode-only instruction: first byte is also last
        bus.opcode = 8'h90;
        exp = '{8'h90};
        run_instr("single", exp, 0);

        // Backpressure: toggling ready, then toggling with a long stall on disp
        set_case1();
        exp = '{8'h81, 8'h44, 8'h88, 8'h10, 8'h78, 8'h56, 8'h34, 8'h12};
        run_instr("bp_toggle", exp, 1);
        set_case1();
        run_instr("bp_stall", exp, 2);

        // disp-only disp8, then a back-to-back imm8 instruction held on in_valid
        bus.opcode = 8'hEB; bus.disp_only8 = 1'b1; bus.disp = 32'hFFFFFF80;
        bus.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        clear_fields();
        bus.in_valid = 1'b1; bus.opcode = 8'h6A;
        bus.has_imm = 1'b1; bus.imm_1byte = 1'b1; bus.imm = 32'h0000007F;
        check("b2b/b0", 32'(bus.out_byte), 32'hEB);
        check("b2b/b0_last", 32'(bus.out_last), 32'd0);
        check("b2b/len0", 32'(bus.instr_len), 32'd2);
        @(posedge clk); @(negedge clk);
        check("b2b/b1", 32'(bus.out_byte), 32'h80);
        check("b2b/b1_last", 32'(bus.out_last), 32'd1);
        check("b2b/b1_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); @(negedge clk);
        check("b2b/gap_valid", 32'(bus.out_valid), 32'd0);
        check("b2b/gap_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        check("b2b/n0_valid", 32'(bus.out_valid), 32'd1);
        check("b2b/n0", 32'(bus.out_byte), 32'h6A);
        check("b2b/n_len", 32'(bus.instr_len), 32'd2);
        @(posedge clk); @(negedge clk);
        check("b2b/n1", 32'(bus.out_byte), 32'h7F);
        check("b2b/n1_last", 32'(bus.out_last), 32'd1);
        @(posedge clk); @(negedge clk);
        check("b2b/end_valid", 32'(bus.out_valid), 32'd0);
        clear_fields();

        // Asynchronous reset during the immediate bytes
        set_case1();
        bus.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rstmid/pos", 32'(bus.out_byte), 32'h56);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid/valid", 32'(bus.out_valid), 32'd0);
        check("rstmid/in_ready", 32'(bus.in_ready), 32'd1);
        check("rstmid/byte", 32'(bus.out_byte), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("rstmid/after_valid%0d", i), 32'(bus.out_valid), 32'd0);
            check($sformatf("rstmid/after_ready%0d", i), 32'(bus.in_ready), 32'd1);
        end

        // Encoder still works after the abort
        clear_fields();
        bus.opcode = 8'h68; bus.has_imm = 1'b1; bus.imm = 32'hCAFEF00D;
        exp = '{8'h68, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
        run_instr("imm32", exp, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/encode_opnd_bytes.md
# encode_opnd_bytes

Serializing x86 instruction encoder, the inverse of the decode-side operand signal logic. It accepts one instruction's fields: prefix flags, opcode, ModR/M, SIB, displacement and immediate. It emits the instruction as a little-endian byte stream, one byte per cycle, under a valid/ready handshake. It sits in the test-vector and witness generation path and feeds bytes to the fetch/unescape front end. Its presence rules for SIB, displacement and immediate match the decoder's, so encode→decode round-trips.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  encoder can accept an instruction.
- prefix_operand_16bit  in  1  emit 0x66; selects imm16 unless imm_1byte is set.
- prefix_address_16bit  in  1  emit 0x67; suppresses SIB.
- escape  in  1  emit 0x0F before the opcode.
- opcode  in  8  primary opcode byte.
- has_modrm  in  1  instruction carries a ModR/M byte.
- modrm  in  8  ModR/M byte.
- sib  in  8  SIB byte; used only when SIB is present.
- disp_only8, disp_only32  in  1 each  displacement-only forms with no ModR/M; ignored when has_modrm=1.
- disp  in  32  displacement; the low byte is used for disp8.
- has_imm, imm_1byte  in  1 each  immediate present; 1-byte immediate.
- imm  in  32  immediate value.
- out_valid  out  1  out_byte valid.
- out_ready  in  1  downstream accepts the byte.
- out_byte  out  8  current instruction byte.
- out_last  out  1  current byte is the final byte of the instruction.
- instr_len  out  4  total byte count; valid whenever out_valid=1.

## Operation
- Accept when in_valid && in_ready. All inputs are latched; later input changes have no effect.
- Derived flags, computed once at accept from the latched values:
  - reg_direct = has_modrm && mod==2'b11.
  - has_sib = has_modrm && !prefix_address_16bit && !reg_direct && rm==3'b100.
  - ModR/M displacement cases (has_modrm && !reg_direct):
    - disp32 when mod==2'b10, or when mod==2'b00 && rm==3'b101.
    - disp8 when mod==2'b01.
  - Displacement-only cases (has_modrm=0):
    - disp_only32 → disp32.
    - disp_only8 → disp8.
    - If both are set, disp32 wins.
  - Immediate length, highest priority first:
    - !has_imm → 0.
    - imm_1byte → 1.
    - prefix_operand_16bit → 2.
    - otherwise → 4.
- instr_len = prefix count + escape + 1 + has_modrm + has_sib + disp_len + imm_len. The maximum is 14.
- FSM states: IDLE, P66, P67, ESC, OPC, MODRM, SIB, DISP, IMM.
  - From IDLE, accept goes to the first applicable state in the order P66→P67→ESC→OPC.
  - From OPC onward the order is MODRM→SIB→DISP→IMM; absent fields are skipped.
  - A 2-bit byte counter indexes DISP and IMM. Byte k is value[8k+7:8k], so output is little-endian.
  - The counter resets to 0 on entry to each of DISP and IMM.
  - A state advances only when out_valid && out_ready.
  - On the byte with out_last=1, the FSM returns to IDLE.
- out_valid=1 in every non-IDLE state. in_ready=1 only in IDLE.
- out_byte and out_last are registered; they hold stable while out_valid && !out_ready.
- Reset value of every output after rst_n low: in_ready=1, out_valid=0, out_byte=0, out_last=0, instr_len=0.
- Reset mid-instruction aborts it immediately: no further bytes are emitted, and the FSM is in IDLE when rst_n rises.

## Timing
- Latency: accept at edge N; the first byte is valid after edge N (cycle N+1).
- Throughput: with out_ready held high, an instruction of instr_len bytes occupies instr_len+1 cycles, including the IDLE accept cycle.
- Backpressure: the FSM stalls indefinitely with no byte loss or duplication.
- There is no combinational path from in_* or out_ready to any output.
- Simultaneous last-byte transfer and in_valid: the new instruction is not accepted that cycle. It is accepted in the following IDLE cycle.

## Test plan
- Case: SIB plus immediate.
  - Stimulus: opcode=0x81, has_modrm, modrm=0x44, sib=0x88, disp=0x10, has_imm, imm=0x12345678.
  - Required: bytes 81 44 88 10 78 56 34 12; instr_len=8; out_last on the 8th byte only.
- Case: disp32 via ModR/M.
  - Stimulus: opcode=0x8B, modrm=0x05, disp=0xDEADBEEF.
  - Required: 8B 05 EF BE AD DE; instr_len=6; no SIB byte.
- Case: prefixes, escape and imm16.
  - Stimulus: prefix_operand_16bit, prefix_address_16bit, escape, opcode=0xAF, modrm=0xC4, has_imm, imm=0xABCD.
  - Required: 66 67 0F AF C4 CD AB; len 7.
  - rm=100 in register-direct mode must not produce a SIB byte.
- Case: backpressure.
  - Stimulus: the first scenario, with out_ready toggled 0/1 every cycle, then held 0 for 5 cycles mid-displacement.
  - Required: identical byte sequence; out_byte stable during stalls; in_ready=0 throughout.
- Case: disp-only with imm8.
  - Stimulus: disp_only8, disp=0xFFFFFF80, opcode=0xEB, then back-to-back in_valid with has_imm, imm_1byte, imm=0x7F.
  - Required: EB 80, then one IDLE cycle, then the next instruction's bytes.
- Case: reset mid-instruction.
  - Stimulus: assert rst_n=0 asynchronously during the IMM bytes.
  - Required: out_valid=0 immediately; after release in_ready=1 and no residual bytes appear.
